// File: rtl/psum_link_pkg.sv
// Shared constants and types for the inter-core partial-sum link.
// Used by the receive side now and by the transmit side later.
package psum_link_pkg;

    localparam int BW          = 8;
    localparam int BW_PSUM     = 2 * BW + 4;
    localparam int SUM_W       = BW_PSUM + 4;
    localparam int FIFO_DEPTH  = 4;
    localparam int SYNC_STAGES = 2;
    localparam int CNT_W       = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        ACK        = 2'd1,
        WAIT_SPACE = 2'd2
    } rx_state_e;

    // One extra bit of headroom means the sum of two signed operands can never overflow.
    function automatic logic [SUM_W:0] fuse_sum(input logic [SUM_W-1:0] a,
                                                input logic [SUM_W-1:0] b);
        return {a[SUM_W-1], a} + {b[SUM_W-1], b};
    endfunction

endpackage

// File: rtl/psum_rx_fifo.sv
// Circular-buffer FIFO with occupancy count; push is ignored when full, pop when empty.
// Shared by the receive and transmit ends of the partial-sum link.
module psum_rx_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full     = (count_q == (PTR_W+1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push & ~full;
        do_pop   = pop & ~empty;
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        count_d  = count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; the count guards every read, so stale data is never seen.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/psum_hs_rx.sv
// Receive end of the 4-phase partial-sum link: synchronise req, buffer partner sums,
// and fuse each buffered word with the local core sum onto a valid/ready output.
module psum_hs_rx
    import psum_link_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             rx_req,
    input  logic [SUM_W-1:0] rx_sum_in,
    output logic             rx_ack,
    input  logic [SUM_W-1:0] local_sum,
    input  logic             local_valid,
    output logic             local_ready,
    output logic [SUM_W:0]   fused_sum,
    output logic             fused_valid,
    input  logic             fused_ready,
    output logic [CNT_W-1:0] fifo_count,
    output logic             proto_err
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   req_s;

    rx_state_e              state_q, state_d;
    logic                   rx_ack_q, rx_ack_d;
    logic                   proto_err_q, proto_err_d;
    logic                   fused_valid_q, fused_valid_d;
    logic [SUM_W:0]         fused_sum_q, fused_sum_d;

    logic                   push;
    logic                   fire;
    logic [SUM_W-1:0]       fifo_head;
    logic                   fifo_full;
    logic                   fifo_empty;

    psum_rx_fifo #(
        .WIDTH (SUM_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (rx_sum_in),
        .pop       (fire),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign sync_d = {sync_q[SYNC_STAGES-2:0], rx_req};
    assign req_s  = sync_q[SYNC_STAGES-1];

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        rx_ack_d    = rx_ack_q;
        proto_err_d = proto_err_q;
        push        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_s) begin
                    if (!fifo_full) begin
                        push     = 1'b1;
                        rx_ack_d = 1'b1;
                        state_d  = ACK;
                    end else begin
                        state_d  = WAIT_SPACE;
                    end
                end
            end
            WAIT_SPACE: begin
                // A withdrawn request wins: rx_sum_in is no longer guaranteed stable.
                if (!req_s) begin
                    proto_err_d = 1'b1;
                    state_d     = IDLE;
                end else if (!fifo_full) begin
                    push     = 1'b1;
                    rx_ack_d = 1'b1;
                    state_d  = ACK;
                end
            end
            ACK: begin
                if (!req_s) begin
                    rx_ack_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: begin
                rx_ack_d = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

    always_comb begin
        fire          = ~fifo_empty & local_valid & (~fused_valid_q | fused_ready);
        fused_sum_d   = fused_sum_q;
        fused_valid_d = fused_valid_q;
        if (fire) begin
            fused_sum_d   = fuse_sum(local_sum, fifo_head);
            fused_valid_d = 1'b1;
        end else if (fused_ready) begin
            fused_valid_d = 1'b0;
        end
    end

    // NOTE: state is updated only with non-blocking assignments so all flops sample the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q        <= '0;
            state_q       <= IDLE;
            rx_ack_q      <= 1'b0;
            proto_err_q   <= 1'b0;
            fused_valid_q <= 1'b0;
            fused_sum_q   <= '0;
        end else begin
            sync_q        <= sync_d;
            state_q       <= state_d;
            rx_ack_q      <= rx_ack_d;
            proto_err_q   <= proto_err_d;
            fused_valid_q <= fused_valid_d;
            fused_sum_q   <= fused_sum_d;
        end
    end

    assign rx_ack      = rx_ack_q;
    assign proto_err   = proto_err_q;
    assign fused_valid = fused_valid_q;
    assign fused_sum   = fused_sum_q;
    assign local_ready = fire;

endmodule

// File: doc/psum_hs_rx.md
Name: psum_hs_rx

Overview:
Receive end of the inter-core partial-sum req/ack link between two fullchip instances.
- Accepts the partner core's summed psum over a 4-phase request/acknowledge handshake and buffers it in a small FIFO.
- Pairs each buffered word with the local core's sum and emits the signed total to the downstream normaliser over a valid/ready interface.
- Sits inside fullchip between the rx_req/rx_ack/partner-sum pins and the local output stage.

Parameters:
bw, 8, activation/weight bit width
bw_psum, 2*bw+4 (20), per-column psum width
sum_w, bw_psum+4 (24), width of exchanged core sum
fifo_depth, 4, receive FIFO entries (power of two, >=2)
sync_stages, 2, req synchroniser flops (>=2)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
rx_req  input  1  partner request (4-phase, may be asynchronous to clk)
rx_sum_in  input  sum_w  partner sum; stable while rx_req high until rx_ack seen high
rx_ack  output  1  acknowledge to partner
local_sum  input  sum_w  local core sum, signed
local_valid  input  1  local_sum valid
local_ready  output  1  local_sum consumed this cycle
fused_sum  output  sum_w+1  signed local + partner
fused_valid  output  1  fused_sum valid
fused_ready  input  1  downstream accepts fused_sum
fifo_count  output  $clog2(fifo_depth)+1  entries held
proto_err  output  1  sticky protocol-violation flag

Behaviour:
- Clock and reset: one clock clk. Reset is synchronous and active-high on port reset. On reset, all of the following are 0: rx_ack, local_ready, fused_valid, fused_sum, fifo_count, proto_err. Synchroniser flops clear, FIFO pointers clear, FSM goes to IDLE.
- Synchroniser: rx_req passes through sync_stages flops to give req_s. Default latency from rx_req pin to req_s is 2 cycles.
- Handshake FSM (registered rx_ack):
  - IDLE, req_s=1, FIFO not full: write rx_sum_in (sampled this edge) into FIFO, rx_ack<=1, go to ACK.
  - IDLE, req_s=1, FIFO full: go to WAIT_SPACE; rx_ack stays 0.
  - WAIT_SPACE, FIFO not full: capture, rx_ack<=1, go to ACK.
  - WAIT_SPACE, req_s=0: set proto_err (request withdrawn unacknowledged), go to IDLE, nothing written.
  - ACK, req_s=0: rx_ack<=0, go to IDLE.
  - ACK, req_s=1: hold.
- Timing: with an empty FIFO, rx_ack rises on the 3rd edge after rx_req rises and falls on the 3rd edge after rx_req falls. There is exactly one capture per req rising phase.
- Full check: uses the current-cycle full flag. At full, a same-cycle pop does not enable capture; capture happens next cycle.
- FIFO: circular buffer, wrap-around pointers, count 0..fifo_depth. A simultaneous push and pop when not full leaves the count unchanged. Read on empty is impossible by construction.
- Fuse stage:
  - fire = fifo non-empty & local_valid & (~fused_valid | fused_ready).
  - On fire: fused_sum <= sext(local_sum) + sext(fifo_head) in two's complement, width sum_w+1, no saturation and no overflow possible. Also fused_valid<=1, FIFO pop, local_ready=1 (combinational, same cycle).
  - fused_valid clears when fused_ready=1 and no fire occurs.
  - fused_sum holds its value while fused_valid=1 and fused_ready=0.
  - local_valid with an empty FIFO gives local_ready=0 (local stalls).
- Reset mid-transaction: FIFO contents are discarded and rx_ack drops at that edge. If rx_req is still high after reset, it is treated as a new request and captured again. The partner must tolerate the duplicate, so system reset is global.
- proto_err clears only on reset.

Decomposition:
- Shared package psum_link_pkg:
  - SUM_W = 24 (BW_PSUM+4)
  - FIFO_DEPTH = 4
  - SYNC_STAGES = 2
  - rx FSM state enum {IDLE, ACK, WAIT_SPACE}
- One sub-module: psum_rx_fifo (parameterised width/depth, push/pop/full/empty/count). Used here and reusable by the future transmit side.
- Synchroniser and FSM stay inline.

Test Plan:
- Single transfer: rx_sum_in=24'h000123, rx_req pulse held until ack, then local_sum=24'h000010 with local_valid → rx_ack high 3 cycles after req, low 3 cycles after req drop; fused_sum=25'h0000133, fused_valid for one cycle with fused_ready=1.
- Signed add: partner 24'hFFFFF0 (-16), local 24'h000005 → fused_sum=25'h1FFFFF5 (-11). Extremes 24'h800000 + 24'h800000 → 25'h1000000.
- Backpressure/full: 5 transfers of 1..5, local_valid=0 → first 4 acked, fifo_count=4, 5th waits with rx_ack=0. Then one local pop → 5th acked next-but-one cycle; outputs emerge in order 1..5.
- Output stall: fused_ready=0 with data and local_valid → one fire, fused_sum held, local_ready=0 until fused_ready=1; no loss or duplication.
- Protocol error: fill FIFO, raise req, drop it before ack → proto_err=1 sticky, fifo_count stays 4; reset clears it.
- Reset mid-op: reset asserted while in ACK with 2 entries → next cycle rx_ack=0, fifo_count=0, fused_valid=0; req still high → recaptured, rx_ack high 3 cycles after reset release.
